// File: rtl/e203_soc_demo_top.sv
// E203 board demo top: emulated PLL lock and internal reset, 8N1 UART echo console on GPIO
// pins with receive status mirrored on gpio_out, and safe tie-offs for JTAG/QSPI/AON pins.
module e203_soc_demo_top #(
  parameter int unsigned CLK_HZ      = 27_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned HB_DIV      = 13_500_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  input  logic [3:0]  qspi_in,
  output logic [3:0]  qspi_out,
  output logic        qspi_sck,
  output logic        qspi_cs,
  input  logic        dbgmode0_n,
  input  logic        dbgmode1_n,
  input  logic        dbgmode3_n,
  input  logic        bootrom_n,
  input  logic        aon_pmu_dwakeup_n,
  output logic        aon_pmu_padrst,
  output logic        aon_pmu_vddpaden
);

  localparam int unsigned BIT_DIV = CLK_HZ / BAUD;
  localparam int unsigned CW      = $clog2(BIT_DIV);
  localparam int unsigned LW      = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned HW      = $clog2(HB_DIV);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_DIV / 2 - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST   = HW'(HB_DIV - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

  logic [LW-1:0] lock_cnt;
  logic          lock;
  logic          sys_rst;

  logic          rx_meta, rx_sync;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_tick;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic [7:0]    last_byte;
  logic [7:0]    rx_cnt;
  logic          frame_err;

  logic          tx_busy, tx_line, tx_done, tx_free;
  logic [CW-1:0] tx_tick;
  logic [3:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          hold_valid;
  logic [7:0]    hold_data;
  logic          overrun;

  logic [HW-1:0] hb_cnt;
  logic          heartbeat;
  logic          unused_inputs;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (!lock) begin
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LOCK_LAST) lock <= 1'b1;
    end
  end

  assign sys_rst = rst | ~lock;

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= gpio_in[16];
      rx_sync <= rx_meta;
    end
  end

  // Stop bit is sampled mid-bit and the FSM returns to idle right away, so a
  // start edge immediately following the stop bit is not missed.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      rx_state  <= RxIdle;
      rx_tick   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      last_byte <= '0;
      rx_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RxIdle: begin
          if (!rx_sync) begin
            rx_state <= RxStart;
            rx_tick  <= '0;
          end
        end
        RxStart: begin
          if (rx_tick == HALF_LAST) begin
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RxIdle : RxData;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        RxData: begin
          if (rx_tick == BIT_LAST) begin
            rx_tick  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RxStop;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        RxStop: begin
          if (rx_tick == BIT_LAST) begin
            rx_tick  <= '0;
            rx_state <= RxIdle;
            if (rx_sync) begin
              rx_valid  <= 1'b1;
              last_byte <= rx_shift;
              rx_cnt    <= rx_cnt + 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_tick <= rx_tick + 1'b1;
          end
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  assign tx_done = tx_busy && (tx_tick == BIT_LAST) && (tx_bit == 4'd9);
  assign tx_free = !tx_busy || tx_done;

  // last_byte carries the byte accepted in the same cycle rx_valid is high.
  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      tx_busy    <= 1'b0;
      tx_line    <= 1'b1;
      tx_tick    <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      overrun    <= 1'b0;
    end else if (tx_free) begin
      if (hold_valid || rx_valid) begin
        tx_busy  <= 1'b1;
        tx_line  <= 1'b0;
        tx_tick  <= '0;
        tx_bit   <= '0;
        tx_shift <= hold_valid ? hold_data : last_byte;
        if (hold_valid) begin
          hold_valid <= rx_valid;
          hold_data  <= last_byte;
        end
      end else begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end
    end else begin
      if (tx_tick == BIT_LAST) begin
        tx_tick  <= '0;
        tx_bit   <= tx_bit + 1'b1;
        tx_line  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[7:1]};
      end else begin
        tx_tick <= tx_tick + 1'b1;
      end
      if (rx_valid) begin
        if (!hold_valid) begin
          hold_valid <= 1'b1;
          hold_data  <= last_byte;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign gpio_out = {7'd0, bootrom_n, dbgmode3_n, dbgmode1_n, dbgmode0_n, overrun, heartbeat,
                     frame_err, tx_line, 1'b1, rx_cnt, last_byte};

  assign tdo              = 1'b0;
  assign qspi_out         = 4'h0;
  assign qspi_sck         = 1'b0;
  assign qspi_cs          = 1'b1;
  assign aon_pmu_padrst   = ~sys_rst;
  assign aon_pmu_vddpaden = 1'b1;

  assign unused_inputs = ^{tck, tms, tdi, qspi_in, aon_pmu_dwakeup_n, gpio_in[31:17],
                           gpio_in[15:0]};

endmodule

// File: tb/tb_e203_soc_demo_top.sv
// Bench for e203_soc_demo_top: drives UART frames on gpio_in[16], decodes the echo on
// gpio_out[17] and compares status bits against a byte-level model of the console.
`timescale 1ns/1ps
module tb_e203_soc_demo_top;

  localparam int BIT = 234;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tck, tms, tdi;
  logic        tdo;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [3:0]  qspi_in;
  logic [3:0]  qspi_out;
  logic        qspi_sck, qspi_cs;
  logic        dbgmode0_n, dbgmode1_n, dbgmode3_n, bootrom_n;
  logic        aon_pmu_dwakeup_n;
  logic        aon_pmu_padrst, aon_pmu_vddpaden;

  always #18.52 clk_in = ~clk_in;

  e203_soc_demo_top dut (
    .clk_in            (clk_in),
    .rst               (rst),
    .tck               (tck),
    .tms               (tms),
    .tdi               (tdi),
    .tdo               (tdo),
    .gpio_in           (gpio_in),
    .gpio_out          (gpio_out),
    .qspi_in           (qspi_in),
    .qspi_out          (qspi_out),
    .qspi_sck          (qspi_sck),
    .qspi_cs           (qspi_cs),
    .dbgmode0_n        (dbgmode0_n),
    .dbgmode1_n        (dbgmode1_n),
    .dbgmode3_n        (dbgmode3_n),
    .bootrom_n         (bootrom_n),
    .aon_pmu_dwakeup_n (aon_pmu_dwakeup_n),
    .aon_pmu_padrst    (aon_pmu_padrst),
    .aon_pmu_vddpaden  (aon_pmu_vddpaden)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_last;
  logic [7:0] m_cnt;
  logic       m_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ":last_byte"}, 32'(gpio_out[7:0]), 32'(m_last));
    check({tag, ":rx_cnt"}, 32'(gpio_out[15:8]), 32'(m_cnt));
    check({tag, ":const16"}, 32'(gpio_out[16]), 32'd1);
    check({tag, ":frame_err"}, 32'(gpio_out[18]), 32'(m_ferr));
    check({tag, ":heartbeat"}, 32'(gpio_out[19]), 32'd0);
    check({tag, ":overrun"}, 32'(gpio_out[20]), 32'd0);
  endtask

  // A bad stop bit is held low for 3/4 of a bit, then the line idles for an extra bit so the
  // receiver's re-armed start detector rejects the tail of the stop bit.
  task automatic rx_frame(input logic [7:0] b, input bit good);
    gpio_in[16] = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      gpio_in[16] = b[i];
      tick(BIT);
    end
    if (good) begin
      gpio_in[16] = 1'b1;
      tick(BIT);
      m_last = b;
      m_cnt  = m_cnt + 8'd1;
      exp_q.push_back(b);
    end else begin
      gpio_in[16] = 1'b0;
      tick(BIT * 3 / 4);
      gpio_in[16] = 1'b1;
      tick(BIT / 4 + BIT);
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_echo(input string tag);
    tick(2600);
    check({tag, ":echo_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, ":echo_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Passive UART decoder on the TX pin, sampling mid-bit on the falling clock edge.
  initial begin
    logic [7:0] mb;
    forever begin
      @(negedge gpio_out[17]);
      repeat (BIT / 2) @(negedge clk_in);
      mb = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk_in);
        mb[i] = gpio_out[17];
      end
      repeat (BIT) @(negedge clk_in);
      if (gpio_out[17] === 1'b1) got_q.push_back(mb);
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] msg [5];
    bit         good;
    logic [2:0] dbg;

    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h0D; msg[4] = 8'h0A;
    m_last = 8'h00;
    m_cnt  = 8'h00;
    m_ferr = 1'b0;

    rst               = 1'b1;
    tck               = 1'b0;
    tms               = 1'b1;
    tdi               = 1'b0;
    qspi_in           = 4'($urandom);
    gpio_in           = $urandom;
    gpio_in[16]       = 1'b1;
    dbg               = 3'($urandom);
    {dbgmode3_n, dbgmode1_n, dbgmode0_n} = dbg;
    bootrom_n         = 1'($urandom);
    aon_pmu_dwakeup_n = 1'b1;

    tick(10);
    check("reset:gpio_low", 32'(gpio_out[20:0]), 32'h30000);
    check("reset:gpio_high", 32'(gpio_out[31:21]), 32'({7'd0, bootrom_n, dbg}));
    check("reset:padrst", 32'(aon_pmu_padrst), 32'd0);
    check("tie:tdo", 32'(tdo), 32'd0);
    check("tie:qspi_out", 32'(qspi_out), 32'd0);
    check("tie:qspi_sck", 32'(qspi_sck), 32'd0);
    check("tie:qspi_cs", 32'(qspi_cs), 32'd1);
    check("tie:vddpaden", 32'(aon_pmu_vddpaden), 32'd1);

    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      check("lock:padrst", 32'(aon_pmu_padrst), (i == 16) ? 32'd1 : 32'd0);
    end
    check_status("post_lock");

    rx_frame(8'h41, 1'b1);
    check_status("single");
    check_echo("single");

    for (int i = 0; i < 5; i++) rx_frame(msg[i], 1'b1);
    check_status("burst");
    check_echo("burst");

    gpio_in[16] = 1'b0;
    tick(54);
    gpio_in[16] = 1'b1;
    tick(400);
    check_status("glitch");

    rx_frame(8'h55, 1'b0);
    check_status("frame_err");
    check_echo("frame_err");

    for (int k = 0; k < 6; k++) begin
      tick($urandom_range(0, 300));
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      rx_frame(b, good);
      check_status("random");
    end
    check_echo("random");

    // Echo of 0x00 is mid data bits when a second frame is cut off by reset.
    rx_frame(8'h00, 1'b1);
    gpio_in[16] = 1'b0;
    tick(BIT);
    b = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      gpio_in[16] = b[i];
      tick(BIT);
    end
    check("midrst:tx_busy", 32'(gpio_out[17]), 32'd0);
    rst         = 1'b1;
    gpio_in[16] = 1'b1;
    tick(1);
    check("midrst:tx_idle", 32'(gpio_out[17]), 32'd1);
    check("midrst:gpio_low", 32'(gpio_out[20:0]), 32'h30000);
    check("midrst:padrst", 32'(aon_pmu_padrst), 32'd0);
    tick(4);
    rst = 1'b0;
    tick(20);
    m_last = 8'h00;
    m_cnt  = 8'h00;
    m_ferr = 1'b0;
    tick(BIT * 12);
    got_q.delete();
    exp_q.delete();
    check_status("after_reset");

    b = 8'($urandom);
    rx_frame(b, 1'b1);
    check_status("recover");
    check_echo("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
